// File: rtl/streetlight_sensor_conditioner.sv
// streetlight_sensor_conditioner
//   Produces clean, registered `day` and `veh_detect` decisions for the adaptive streetlight FSM.
//   Ambient light: threshold hysteresis plus DAY_CONFIRM consecutive-sample confirmation.
//   Vehicle loop: 2-flop synchroniser, VEH_DEBOUNCE-cycle debounce, VEH_HOLD-cycle hold stretch.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   lux_valid  in   qualifies lux for one cycle
//   lux        in   [7:0] ambient light sample, unsigned
//   veh_raw    in   asynchronous vehicle loop / PIR level
//   day        out  registered, 1 = daylight confirmed
//   veh_detect out  registered, 1 = vehicle present or within hold window
//   day_change out  one-cycle pulse in the cycle `day` toggles
//   veh_count  out  [15:0] saturating count of qualified vehicle events
//
// Configuration macro
//   SENSOR_VEH_COUNT_EN  compiles in the veh_count register; otherwise veh_count is tied to zero.

module streetlight_sensor_conditioner #(
   parameter logic [7:0]  DAY_ON_TH    = 8'd160,
   parameter logic [7:0]  DAY_OFF_TH   = 8'd96,
   parameter int unsigned DAY_CONFIRM  = 16,
   parameter int unsigned VEH_DEBOUNCE = 4,
   parameter int unsigned VEH_HOLD     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lux_valid,
   input  logic [7:0]  lux,
   input  logic        veh_raw,
   output logic        day,
   output logic        veh_detect,
   output logic        day_change,
   output logic [15:0] veh_count
);

   localparam logic [7:0]  DayConfirm  = 8'(DAY_CONFIRM);
   localparam logic [7:0]  VehDebounce = 8'(VEH_DEBOUNCE);
   localparam logic [15:0] VehHold     = 16'(VEH_HOLD);

   typedef enum logic [1:0] {StNight, StToDay, StDay, StToNight} day_state_e;
   typedef enum logic [1:0] {StVIdle, StVQual, StVActive, StVHold} veh_state_e;

   // ---------------- Day path ----------------
   day_state_e day_state_q, day_state_d;
   logic [7:0] cc_q, cc_d;
   logic       day_q, day_d;
   logic       day_change_q, day_change_d;
   logic       lux_on, lux_off;

   assign lux_on  = (lux >= DAY_ON_TH);
   assign lux_off = (lux <= DAY_OFF_TH);

   always_comb begin
      day_state_d  = day_state_q;
      cc_d         = cc_q;
      day_d        = day_q;
      day_change_d = 1'b0;
      if (lux_valid) begin
         case (day_state_q)
            StNight: begin
               if (lux_on) begin
                  day_state_d = StToDay;
                  cc_d        = 8'd1;
               end
            end
            StToDay: begin
               if (!lux_on) begin
                  day_state_d = StNight;
                  cc_d        = 8'd0;
               end else if (cc_q + 8'd1 == DayConfirm) begin
                  day_state_d  = StDay;
                  cc_d         = 8'd0;
                  day_d        = 1'b1;
                  day_change_d = 1'b1;
               end else begin
                  cc_d = cc_q + 8'd1;
               end
            end
            StDay: begin
               if (lux_off) begin
                  day_state_d = StToNight;
                  cc_d        = 8'd1;
               end
            end
            StToNight: begin
               if (!lux_off) begin
                  day_state_d = StDay;
                  cc_d        = 8'd0;
               end else if (cc_q + 8'd1 == DayConfirm) begin
                  day_state_d  = StNight;
                  cc_d         = 8'd0;
                  day_d        = 1'b0;
                  day_change_d = 1'b1;
               end else begin
                  cc_d = cc_q + 8'd1;
               end
            end
            default: begin
               day_state_d = StNight;
               cc_d        = 8'd0;
               day_d       = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         day_state_q  <= StNight;
         cc_q         <= 8'd0;
         day_q        <= 1'b0;
         day_change_q <= 1'b0;
      end else begin
         day_state_q  <= day_state_d;
         cc_q         <= cc_d;
         day_q        <= day_d;
         day_change_q <= day_change_d;
      end
   end

   assign day        = day_q;
   assign day_change = day_change_q;

   // ---------------- Vehicle path ----------------
   logic        s1_q, s2_q;
   veh_state_e  veh_state_q, veh_state_d;
   logic [7:0]  db_q, db_d;
   logic [15:0] hold_q, hold_d;
   logic        veh_q, veh_d;
   logic        veh_event;

   always_comb begin
      veh_state_d = veh_state_q;
      db_d        = db_q;
      hold_d      = hold_q;
      veh_d       = veh_q;
      veh_event   = 1'b0;
      case (veh_state_q)
         StVIdle: begin
            if (s2_q) begin
               veh_state_d = StVQual;
               db_d        = 8'd1;
            end
         end
         StVQual: begin
            if (!s2_q) begin
               veh_state_d = StVIdle;
               db_d        = 8'd0;
            end else if (db_q + 8'd1 == VehDebounce) begin
               veh_state_d = StVActive;
               db_d        = 8'd0;
               veh_d       = 1'b1;
               veh_event   = 1'b1;
            end else begin
               db_d = db_q + 8'd1;
            end
         end
         StVActive: begin
            if (!s2_q) begin
               veh_state_d = StVHold;
               hold_d      = 16'd1;
            end
         end
         StVHold: begin
            // Returning high inside the hold window is the same vehicle: no re-debounce, no count.
            if (s2_q) begin
               veh_state_d = StVActive;
               hold_d      = 16'd0;
            end else if (hold_q + 16'd1 == VehHold) begin
               veh_state_d = StVIdle;
               hold_d      = 16'd0;
               veh_d       = 1'b0;
            end else begin
               hold_d = hold_q + 16'd1;
            end
         end
         default: begin
            veh_state_d = StVIdle;
            db_d        = 8'd0;
            hold_d      = 16'd0;
            veh_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         veh_state_q <= StVIdle;
         db_q        <= 8'd0;
         hold_q      <= 16'd0;
         veh_q       <= 1'b0;
      end else begin
         s1_q        <= veh_raw;
         s2_q        <= s1_q;
         veh_state_q <= veh_state_d;
         db_q        <= db_d;
         hold_q      <= hold_d;
         veh_q       <= veh_d;
      end
   end

   assign veh_detect = veh_q;

`ifdef SENSOR_VEH_COUNT_EN
   logic [15:0] veh_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         veh_count_q <= 16'h0000;
      end else if (veh_event && (veh_count_q != 16'hFFFF)) begin
         veh_count_q <= veh_count_q + 16'd1;
      end
   end

   assign veh_count = veh_count_q;
`else
   logic unused_veh_event;
   assign unused_veh_event = veh_event;
   assign veh_count        = 16'h0000;
`endif

endmodule

// File: tb/tb_streetlight_sensor_conditioner.sv
// Directed self-checking bench for streetlight_sensor_conditioner (default parameters).
// Inputs change and outputs are sampled on the falling edge of clk.

module tb_streetlight_sensor_conditioner;

   logic        clk;
   logic        rst_n;
   logic        lux_valid;
   logic [7:0]  lux;
   logic        veh_raw;
   logic        day;
   logic        veh_detect;
   logic        day_change;
   logic [15:0] veh_count;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef SENSOR_VEH_COUNT_EN
   localparam logic [15:0] ExpOne = 16'd1;
`else
   localparam logic [15:0] ExpOne = 16'd0;
`endif

   streetlight_sensor_conditioner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lux_valid  (lux_valid),
      .lux        (lux),
      .veh_raw    (veh_raw),
      .day        (day),
      .veh_detect (veh_detect),
      .day_change (day_change),
      .veh_count  (veh_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One valid sample, consumed by the next rising edge; returns after that edge.
   task automatic lux_sample(input logic [7:0] v);
      lux       = v;
      lux_valid = 1'b1;
      @(negedge clk);
      lux_valid = 1'b0;
   endtask

   task automatic veh_pulse(input int hi, input int lo);
      veh_raw = 1'b1;
      idle(hi);
      veh_raw = 1'b0;
      idle(lo);
   endtask

   initial begin
      rst_n     = 1'b0;
      lux_valid = 1'b1;
      lux       = 8'd255;
      veh_raw   = 1'b1;

      // Reset held for two edges with active-looking inputs.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rst_day", day, 0);
         check_eq("rst_veh", veh_detect, 0);
         check_eq("rst_cnt", veh_count, 0);
         check_eq("rst_chg", day_change, 0);
      end
      rst_n     = 1'b1;
      lux_valid = 1'b0;
      veh_raw   = 1'b0;
      @(negedge clk);
      check_eq("post_rst_day", day, 0);
      check_eq("post_rst_veh", veh_detect, 0);
      check_eq("post_rst_cnt", veh_count, 0);

      // Day entry: 16 samples of 200, toggle on the 16th.
      for (int i = 0; i < 16; i++) begin
         lux_sample(8'd200);
         check_eq("entry_day", day, (i == 15));
         check_eq("entry_chg", day_change, (i == 15));
      end
      idle(1);
      check_eq("entry_day_hold", day, 1);
      check_eq("entry_chg_pulse", day_change, 0);

      // Day exit: 16 samples of 50.
      for (int i = 0; i < 16; i++) begin
         lux_sample(8'd50);
         check_eq("exit_day", day, (i != 15));
         check_eq("exit_chg", day_change, (i == 15));
      end

      // Hysteresis abort with lux_valid gaps: 10x200, 128, 15x200 keeps night.
      for (int i = 0; i < 10; i++) begin
         lux_sample(8'd200);
         idle(1);
      end
      lux_sample(8'd128);
      idle(2);
      for (int i = 0; i < 15; i++) begin
         lux_sample(8'd200);
         idle(i % 3);
         check_eq("abort_day", day, 0);
      end
      // 16th consecutive qualifier exactly at DAY_ON_TH.
      lux_sample(8'd160);
      check_eq("on_th_day", day, 1);
      check_eq("on_th_chg", day_change, 1);

      // Exit at exactly DAY_OFF_TH, with a 97 abort first.
      for (int i = 0; i < 5; i++) lux_sample(8'd96);
      lux_sample(8'd97);
      for (int i = 0; i < 15; i++) begin
         lux_sample(8'd96);
         check_eq("off_abort_day", day, 1);
      end
      lux_sample(8'd96);
      check_eq("off_th_day", day, 0);
      check_eq("off_th_chg", day_change, 1);

      // Vehicle high glitch of 3 cycles never asserts.
      veh_raw = 1'b1;
      idle(3);
      veh_raw = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         check_eq("glitch_veh", veh_detect, 0);
      end

      // Vehicle held high: detect after edge k+5 (6th edge counting k as 1).
      veh_raw = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         check_eq("deb_veh", veh_detect, (j >= 6));
         check_eq("deb_cnt", veh_count, (j >= 6) ? ExpOne : 16'd0);
      end

      // Hold: low 40, high 2, low 70; drop after edge m+65.
      veh_raw = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         check_eq("hold_low40", veh_detect, 1);
      end
      veh_raw = 1'b1;
      idle(2);
      veh_raw = 1'b0;
      for (int j = 1; j <= 70; j++) begin
         @(negedge clk);
         check_eq("hold_drop", veh_detect, (j < 66));
      end
      check_eq("hold_cnt", veh_count, ExpOne);

      // Reset mid-hold discards progress.
      veh_pulse(10, 20);
      check_eq("mid_hold_veh", veh_detect, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_veh", veh_detect, 0);
      check_eq("mid_rst_cnt", veh_count, 0);
      check_eq("mid_rst_day", day, 0);
      rst_n = 1'b1;
      idle(80);
      check_eq("after_rst_veh", veh_detect, 0);
      check_eq("after_rst_chg", day_change, 0);

`ifdef SENSOR_VEH_COUNT_EN
      // Preload near the top, then four events: count saturates without wrapping.
      dut.veh_count_q = 16'hFFFC;
      veh_pulse(8, 70);
      check_eq("sat_fffd", veh_count, 16'hFFFD);
      veh_pulse(8, 70);
      check_eq("sat_fffe", veh_count, 16'hFFFE);
      veh_pulse(8, 70);
      check_eq("sat_ffff", veh_count, 16'hFFFF);
      veh_pulse(8, 70);
      check_eq("sat_hold", veh_count, 16'hFFFF);
`else
      veh_pulse(8, 70);
      check_eq("nocnt_zero", veh_count, 16'h0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
